cdb_arbiter: RTL and testbench

Round-robin arbiter that shares one common-data-bus (CDB) lane among several functional units completing results. Each cycle it grants at most one valid requester and registers that requester's result onto the CDB lane, which drives the physical register file write port, wakeup in the reservation stations and ROB completion. The team instantiates one arbiter per CDB lane, CDB_WIDTH instances in total.

---
 rtl/cdb_arbiter.sv | 108 ++++++++++
 tb/tb_cdb_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for one common-data-bus lane.
// Each cycle it grants at most one valid requester, starting the search at a
// rotating priority pointer, and registers the winner's result onto the lane.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   flush                 mispredict flush; blocks all grants this cycle
//   req_valid             per-requester completed-result flag
//   req_rd_phy/value/rob  per-requester result payload
//   req_ready             one-hot grant (combinational, depends on req_valid)
//   cdb_valid/rd_phy/rd_value/rob_id  registered broadcast, one cycle after grant
module cdb_arbiter #(
  parameter int unsigned NUM_REQ   = 3,
  parameter int unsigned PRF_IDX_W = 6,
  parameter int unsigned ROB_IDX_W = 5
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                flush,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0][PRF_IDX_W-1:0]   req_rd_phy,
  input  logic [NUM_REQ-1:0][31:0]            req_rd_value,
  input  logic [NUM_REQ-1:0][ROB_IDX_W-1:0]   req_rob_id,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic                                cdb_valid,
  output logic [PRF_IDX_W-1:0]                cdb_rd_phy,
  output logic [31:0]                         cdb_rd_value,
  output logic [ROB_IDX_W-1:0]                cdb_rob_id
);

  localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned DATA_W = 32;

  logic [PTR_W-1:0]     ptr;
  logic [PTR_W-1:0]     ptr_next;
  logic [PTR_W-1:0]     scan_idx;
  logic [PTR_W-1:0]     grant_idx;
  logic                 grant_any;
  logic [PRF_IDX_W-1:0] sel_phy;
  logic [DATA_W-1:0]    sel_value;
  logic [ROB_IDX_W-1:0] sel_rob;

  // Grant search: first valid requester at or after ptr, wrapping modulo NUM_REQ.
  // Reset and flush both suppress every grant.
  always_comb begin
    req_ready = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    if (rst_n && !flush) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        scan_idx = PTR_W'((32'(ptr) + k) % NUM_REQ);
        if (!grant_any && req_valid[scan_idx]) begin
          grant_any = 1'b1;
          grant_idx = scan_idx;
        end
      end
    end
    if (grant_any) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Payload select: req_ready is one-hot, so an OR of masked payloads suffices.
  always_comb begin
    sel_phy   = '0;
    sel_value = '0;
    sel_rob   = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (req_ready[i]) begin
        sel_phy   = sel_phy   | req_rd_phy[i];
        sel_value = sel_value | req_rd_value[i];
        sel_rob   = sel_rob   | req_rob_id[i];
      end
    end
  end

  // Priority moves to the requester just after the winner.
  always_comb begin
    ptr_next = ptr;
    if (grant_any) begin
      if (32'(grant_idx) == NUM_REQ - 1) begin
        ptr_next = '0;
      end else begin
        ptr_next = grant_idx + PTR_W'(1);
      end
    end
  end

  // Pointer and broadcast register; payload holds when nothing is granted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr          <= '0;
      cdb_valid    <= 1'b0;
      cdb_rd_phy   <= '0;
      cdb_rd_value <= '0;
      cdb_rob_id   <= '0;
    end else begin
      ptr       <= ptr_next;
      cdb_valid <= grant_any;
      if (grant_any) begin
        cdb_rd_phy   <= sel_phy;
        cdb_rd_value <= sel_value;
        cdb_rob_id   <= sel_rob;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: a 3-requester instance for directed cases and a
// 4-requester instance for randomized hold-until-ready traffic, both checked
// every cycle against a queue-free behavioural model of the grant rules.
module tb_cdb_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;

  logic [2:0]        v3;
  logic [2:0][5:0]   phy3;
  logic [2:0][31:0]  val3;
  logic [2:0][4:0]   rob3;
  logic [2:0]        rdy3;
  logic              cv3;
  logic [5:0]        cphy3;
  logic [31:0]       cval3;
  logic [4:0]        crob3;

  logic [3:0]        v4;
  logic [3:0][5:0]   phy4;
  logic [3:0][31:0]  val4;
  logic [3:0][4:0]   rob4;
  logic [3:0]        rdy4;
  logic              cv4;
  logic [5:0]        cphy4;
  logic [31:0]       cval4;
  logic [4:0]        crob4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_REQ(3), .PRF_IDX_W(6), .ROB_IDX_W(5)) dut3 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(v3), .req_rd_phy(phy3), .req_rd_value(val3), .req_rob_id(rob3),
    .req_ready(rdy3), .cdb_valid(cv3), .cdb_rd_phy(cphy3),
    .cdb_rd_value(cval3), .cdb_rob_id(crob3)
  );

  cdb_arbiter #(.NUM_REQ(4), .PRF_IDX_W(6), .ROB_IDX_W(5)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(v4), .req_rd_phy(phy4), .req_rd_value(val4), .req_rob_id(rob4),
    .req_ready(rdy4), .cdb_valid(cv4), .cdb_rd_phy(cphy4),
    .cdb_rd_value(cval4), .cdb_rob_id(crob4)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // First valid index scanning p, p+1, ... modulo n; -1 if none.
  function automatic int pick(input int n, input int p, input logic [7:0] v);
    for (int k = 0; k < n; k++) begin
      if (v[(p + k) % n]) return (p + k) % n;
    end
    return -1;
  endfunction

  // ---------------- behavioural model and per-cycle compare ----------------
  int          mptr   [2];
  logic        mvalid [2];
  logic [5:0]  mphy   [2];
  logic [31:0] mval   [2];
  logic [4:0]  mrob   [2];
  int          wt     [4];

  initial begin
    logic [7:0]  in_v [2];
    logic [5:0]  in_phy [2][8];
    logic [31:0] in_val [2][8];
    logic [4:0]  in_rob [2][8];
    logic [7:0]  g_rdy [2];
    logic        g_v [2];
    logic [5:0]  g_phy [2];
    logic [31:0] g_val [2];
    logic [4:0]  g_rob [2];
    int g, n;
    logic [7:0] exp_rdy;
    for (int d = 0; d < 2; d++) begin
      mptr[d] = 0; mvalid[d] = 1'b0; mphy[d] = '0; mval[d] = '0; mrob[d] = '0;
    end
    for (int i = 0; i < 4; i++) wt[i] = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      in_v[0] = {5'b0, v3};
      in_v[1] = {4'b0, v4};
      for (int i = 0; i < 8; i++) begin
        in_phy[0][i] = (i < 3) ? phy3[i % 3] : 6'd0;
        in_val[0][i] = (i < 3) ? val3[i % 3] : 32'd0;
        in_rob[0][i] = (i < 3) ? rob3[i % 3] : 5'd0;
        in_phy[1][i] = (i < 4) ? phy4[i % 4] : 6'd0;
        in_val[1][i] = (i < 4) ? val4[i % 4] : 32'd0;
        in_rob[1][i] = (i < 4) ? rob4[i % 4] : 5'd0;
      end
      g_rdy[0] = {5'b0, rdy3}; g_v[0] = cv3; g_phy[0] = cphy3; g_val[0] = cval3; g_rob[0] = crob3;
      g_rdy[1] = {4'b0, rdy4}; g_v[1] = cv4; g_phy[1] = cphy4; g_val[1] = cval4; g_rob[1] = crob4;

      for (int d = 0; d < 2; d++) begin
        n = (d == 0) ? 3 : 4;
        g = (rst_n && !flush) ? pick(n, mptr[d], in_v[d]) : -1;
        exp_rdy = (g >= 0) ? (8'd1 << g) : 8'd0;
        chk($sformatf("m%0d_req_ready", d), 32'(g_rdy[d]), 32'(exp_rdy));
        chk($sformatf("m%0d_cdb_valid", d), 32'(g_v[d]), 32'(mvalid[d]));
        chk($sformatf("m%0d_cdb_rd_phy", d), 32'(g_phy[d]), 32'(mphy[d]));
        chk($sformatf("m%0d_cdb_rd_value", d), g_val[d], mval[d]);
        chk($sformatf("m%0d_cdb_rob_id", d), 32'(g_rob[d]), 32'(mrob[d]));
        chk($sformatf("m%0d_xcheck", d),
            32'($isunknown({g_rdy[d], g_v[d], g_phy[d], g_val[d], g_rob[d]})), 32'd0);
        if (d == 1) begin
          chk("onehot0", 32'($onehot0(g_rdy[1])), 32'd1);
          for (int i = 0; i < 4; i++) begin
            if (!rst_n || flush || !in_v[1][i] || g == i) begin
              wt[i] = 0;
            end else begin
              wt[i]++;
              chk($sformatf("fair_wait_r%0d", i), 32'(wt[i] <= 3), 32'd1);
            end
          end
        end
        if (!rst_n) begin
          mptr[d] = 0; mvalid[d] = 1'b0; mphy[d] = '0; mval[d] = '0; mrob[d] = '0;
        end else if (g >= 0) begin
          mvalid[d] = 1'b1;
          mphy[d]   = in_phy[d][g];
          mval[d]   = in_val[d][g];
          mrob[d]   = in_rob[d][g];
          mptr[d]   = (g + 1) % n;
        end else begin
          mvalid[d] = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus with literal expectations ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  initial begin
    logic [2:0] exp_rr [6];
    logic [4:0] exp_rob [6];
    logic [3:0] xfer;
    logic       fl;
    exp_rr  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    exp_rob = '{5'd0, 5'd8, 5'd16, 5'd1, 5'd9, 5'd17};

    rst_n = 1'b0; flush = 1'b0;
    v3 = 3'b111; phy3 = '0; val3 = '0; rob3 = '0;
    v4 = '0;     phy4 = '0; val4 = '0; rob4 = '0;

    // Reset: ready held low despite valid requests.
    sample; chk("rst_ready", 32'(rdy3), 32'd0); chk("rst_cdb_valid", 32'(cv3), 32'd0);
    tick;   sample; chk("rst_ready2", 32'(rdy3), 32'd0);
    tick;   rst_n = 1'b1; v3 = 3'b000;
    sample;
    chk("idle_ready", 32'(rdy3), 32'd0);
    chk("idle_valid", 32'(cv3), 32'd0);
    chk("idle_payload", 32'({cphy3, crob3}) | cval3, 32'd0);

    // Single transfer from requester 1.
    tick; v3 = 3'b010; phy3[1] = 6'd5; val3[1] = 32'hDEADBEEF; rob3[1] = 5'd3;
    sample; chk("single_ready", 32'(rdy3), 32'b010);
    tick; v3 = 3'b000;
    sample;
    chk("single_valid", 32'(cv3), 32'd1);
    chk("single_phy", 32'(cphy3), 32'd5);
    chk("single_value", cval3, 32'hDEADBEEF);
    chk("single_rob", 32'(crob3), 32'd3);

    // ptr=2: requesters 0,1 valid -> wrap to 0, then ptr=1 picks 1 out of 111.
    tick; v3 = 3'b011; rob3[0] = 5'd7; rob3[1] = 5'd4;
    sample; chk("wrap_ready", 32'(rdy3), 32'b001);
    tick; v3 = 3'b111; rob3[0] = 5'd20; rob3[2] = 5'd9;
    sample; chk("after_wrap_ready", 32'(rdy3), 32'b010); chk("wrap_rob", 32'(crob3), 32'd7);

    // Reset mid-stream: the broadcast already registered still shows.
    tick; rst_n = 1'b0;
    sample;
    chk("midrst_valid", 32'(cv3), 32'd1);
    chk("midrst_rob", 32'(crob3), 32'd4);
    chk("midrst_ready", 32'(rdy3), 32'd0);
    tick; sample; chk("midrst_valid_after", 32'(cv3), 32'd0);

    // Rotation from reset with all three requesting, fresh payload after each grant.
    for (int c = 0; c < 6; c++) begin
      tick;
      rst_n = 1'b1;
      v3 = 3'b111;
      for (int i = 0; i < 3; i++) begin
        rob3[i] = 5'(i * 8 + int'(c > i) + int'(c > i + 3));
      end
      sample;
      chk($sformatf("rr_ready_c%0d", c), 32'(rdy3), 32'(exp_rr[c]));
      if (c > 0) chk($sformatf("rr_rob_c%0d", c), 32'(crob3), 32'(exp_rob[c-1]));
    end

    // Flush blocks the grant and leaves ptr at 0.
    tick; v3 = 3'b101; flush = 1'b1;
    sample; chk("flush_ready", 32'(rdy3), 32'd0); chk("rr_rob_last", 32'(crob3), 32'd17);
    tick; flush = 1'b0; v3 = 3'b101;
    sample; chk("post_flush_valid", 32'(cv3), 32'd0); chk("post_flush_ready", 32'(rdy3), 32'b001);
    tick; v3 = 3'b100;
    sample; chk("req2_ready", 32'(rdy3), 32'b100);
    tick; v3 = 3'b000;

    // Randomized hold-until-ready traffic on the 4-requester lane.
    repeat (1000) begin
      @(negedge clk);
      xfer = v4 & rdy4;
      fl   = flush;
      @(posedge clk);
      #1;
      flush = ($urandom_range(0, 31) == 0);
      for (int i = 0; i < 4; i++) begin
        if (fl || xfer[i] || !v4[i]) begin
          v4[i]   = ($urandom_range(0, 2) != 0);
          phy4[i] = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom);
          val4[i] = $urandom;
          rob4[i] = 5'($urandom);
        end
      end
    end
    tick; flush = 1'b0; v4 = '0;
    repeat (3) tick;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
